// File: rtl/sync_fifo_flex.sv
// Single-clock register FIFO with standard (1-cycle registered) or FWFT read, count, thresholds, sticky errors, flush.
// Writes while full and reads while empty are dropped; the sticky error flags record these.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_P   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= af_thresh);
    assign almost_empty = (r_count <= ae_thresh);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // flush wins over both requests, so nothing moves and no error is logged
    assign w_wr_acc = wr_en & ~full & ~flush;
    assign w_rd_acc = rd_en & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + ONE_P;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + ONE_P;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + ONE_C;
                2'b01:   r_count <= r_count - ONE_C;
                default: r_count <= r_count;
            endcase
        end
    end

    // a new error event in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~flush)
                r_overflow <= 1'b1;
            else if (clr_err)
                r_overflow <= 1'b0;
            if (rd_en & empty & ~flush)
                r_underflow <= 1'b1;
            else if (clr_err)
                r_underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else if (flush) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc)
                        r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_data_out;
            assign rd_valid = r_rd_valid;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-mode instance and an FWFT instance.
module tb_sync_fifo_flex;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] data_in;
    logic [4:0] af_thresh, ae_thresh;
    logic [7:0] data_out;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_flush, f_wr_en, f_rd_en, f_clr_err;
    logic [7:0] f_data_in;
    logic [4:0] f_af_thresh, f_ae_thresh;
    logic [7:0] f_data_out;
    logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .data_in(f_data_in),
        .rd_en(f_rd_en), .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .af_thresh(f_af_thresh), .ae_thresh(f_ae_thresh), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; data_in = d; rd_en = 1'b0;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        data_in = 8'h00; af_thresh = 5'd0; ae_thresh = 5'd3;
        f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0;
        f_data_in = 8'h00; f_af_thresh = 5'd16; f_ae_thresh = 5'd0;
        #22;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full_thr0", almost_full, 1);
        af_thresh = 5'd17;
        #1;
        chk("af_thresh_above_depth", almost_full, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: fill to full, overflow on 17th write, drain in order
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t1_count16", count, 16);
        chk("t1_full", full, 1);
        chk("t1_af_never", almost_full, 0);
        push(8'hAA);
        chk("t1_overflow", overflow, 1);
        chk("t1_count_after_drop", count, 16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t1_rd_valid", rd_valid, 1);
            chk("t1_rd_data", data_out, i);
        end
        rd_en = 1'b0;
        tick();
        chk("t1_rd_valid_idle", rd_valid, 0);
        chk("t1_data_held", data_out, 8'h0F);
        chk("t1_empty", empty, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("t1_overflow_clr", overflow, 0);

        // 2: pointer wrap
        for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_rd10_data", data_out, 8'h10 + i);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'h20 + 8'(i));
            chk("t2_count_fill", count, i + 1);
        end
        chk("t2_full", full, 1);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t2_wrap_data", data_out, 8'h20 + i);
            chk("t2_count_drain", count, 15 - i);
        end
        rd_en = 1'b0;

        // 3: simultaneous read/write at count=5 and at full
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        wr_en = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h35 + 8'(i);
            tick();
            chk("t3_rw_data", data_out, 8'h30 + i);
            chk("t3_rw_count", count, 5);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_tail_data", data_out, 8'h38 + i);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h50 + 8'(i));
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t3_full_rw_count", count, 15);
        chk("t3_full_rw_overflow", overflow, 1);
        chk("t3_full_rw_data", data_out, 8'h50);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t3_no_ee_data", data_out, 8'h51 + i);
        end
        rd_en = 1'b0;
        tick();
        chk("t3_empty", empty, 1);

        // 4: thresholds
        af_thresh = 5'd12; ae_thresh = 5'd3;
        for (int i = 1; i <= 13; i++) begin
            push(8'h60 + 8'(i - 1));
            chk("t4_almost_empty", almost_empty, (i <= 3) ? 1 : 0);
            chk("t4_almost_full", almost_full, (i >= 12) ? 1 : 0);
        end
        af_thresh = 5'd14;
        #1;
        chk("t4_af_thresh_change", almost_full, 0);
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_rd_data", data_out, 8'h60 + i);
        end
        rd_en = 1'b0;
        chk("t4_count7", count, 7);

        // 6: flush overrides write; error flags untouched by flush
        flush = 1'b1; wr_en = 1'b1; data_in = 8'h77;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_empty", empty, 1);
        chk("t6_flush_rd_valid", rd_valid, 0);
        chk("t6_flush_data_held", data_out, 8'h65);
        flush = 1'b1; rd_en = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_no_underflow", underflow, 0);
        tick();
        chk("t6_underflow", underflow, 1);
        clr_err = 1'b1;
        tick();
        chk("t6_set_beats_clr", underflow, 1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        chk("t6_underflow_clr", underflow, 0);
        push(8'h99);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("t6_post_flush_data", data_out, 8'h99);

        // reset mid-burst
        for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i));
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hB3;
        tick();
        chk("t6_burst_valid", rd_valid, 1);
        rst = 1'b1;
        #1;
        chk("t6_arst_count", count, 0);
        chk("t6_arst_rd_valid", rd_valid, 0);
        chk("t6_arst_data", data_out, 0);
        chk("t6_arst_empty", empty, 1);
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push(8'hC3);
        chk("t6_after_rst_count", count, 1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("t6_after_rst_data", data_out, 8'hC3);

        // 5: FWFT instance
        f_wr_en = 1'b1; f_data_in = 8'h5A;
        tick();
        f_wr_en = 1'b0;
        chk("t5_fwft_valid", f_rd_valid, 1);
        chk("t5_fwft_data", f_data_out, 8'h5A);
        f_rd_en = 1'b1;
        tick();
        chk("t5_fwft_pop_valid", f_rd_valid, 0);
        chk("t5_fwft_no_underflow", f_underflow, 0);
        tick();
        f_rd_en = 1'b0;
        chk("t5_fwft_underflow", f_underflow, 1);
        f_clr_err = 1'b1; tick(); f_clr_err = 1'b0;
        chk("t5_fwft_underflow_clr", f_underflow, 0);
        f_wr_en = 1'b1; f_data_in = 8'h11; tick();
        f_data_in = 8'h22; tick();
        f_wr_en = 1'b0;
        chk("t5_fwft_head1", f_data_out, 8'h11);
        f_rd_en = 1'b1; tick(); f_rd_en = 1'b0;
        chk("t5_fwft_head2", f_data_out, 8'h22);
        chk("t5_fwft_count", f_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
